// File: rtl/decoder_scan_pkg.sv
// Shared types and the one-hot helper for the scanning decoder.
// Consumers size-trim the MAX_N-bit result of onehot() to their own width.
package decoder_pkg;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_N     = 2 ** MAX_SEL_W;

  typedef enum logic [1:0] {IDLE, RUN, HALT} scan_state_t;

  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    onehot = {{(MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder built on decoder_pkg::onehot.
// SEL_W must not exceed decoder_pkg::MAX_SEL_W.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      i_sel,
  output logic [2**SEL_W-1:0]   o_out
);

  localparam int N_OUT = 2 ** SEL_W;

  logic [MAX_SEL_W-1:0] w_idx_ext;
  logic [MAX_N-1:0]     w_full;

  always_comb begin
    w_idx_ext              = '0;
    w_idx_ext[SEL_W-1:0]   = i_sel;
  end

  assign w_full = onehot(w_idx_ext);
  assign o_out  = w_full[N_OUT-1:0];

  // Bits above N_OUT are always zero for an in-range index.
  if (N_OUT < MAX_N) begin : g_pad
    logic [MAX_N-N_OUT-1:0] w_unused_hi;
    assign w_unused_hi = w_full[MAX_N-1:N_OUT];
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with load/step scanning (wrap or halt at the end).
// Define DECODER_SCAN_DIR_EN to add the `dir` port for down-stepping.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int WRAP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel,
  input  logic               step,
`ifdef DECODER_SCAN_DIR_EN
  input  logic               dir,
`endif
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]   idx,
  output logic               active,
  output logic               done,
  output logic [1:0]         o_dbg_state
);

  localparam int N_OUT = 2 ** SEL_W;

  scan_state_t        r_state;
  scan_state_t        w_state_nxt;
  logic [SEL_W-1:0]   r_idx;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic [SEL_W-1:0]   w_idx_step;
  logic [N_OUT-1:0]   r_out;
  logic [N_OUT-1:0]   w_dec;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_dir;
  logic               w_term;

`ifdef DECODER_SCAN_DIR_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  // Modular +/-1 gives wrap-around for free in both directions.
  assign w_term     = w_dir ? (r_idx == '0) : (r_idx == '1);
  assign w_idx_step = w_dir ? (r_idx - 1'b1) : (r_idx + 1'b1);

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .i_sel (w_idx_nxt),
    .o_out (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_out   <= (w_state_nxt == RUN) ? w_dec : '0;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    if (en) begin
      if (load) begin
        w_state_nxt = RUN;
        w_idx_nxt   = sel;
      end else if (step && (r_state == RUN)) begin
        w_done_nxt = w_term;
        if (w_term && (WRAP == 0)) begin
          w_state_nxt = HALT;
        end else begin
          w_idx_nxt = w_idx_step;
        end
      end
    end
  end

  always_comb begin
    out         = r_out;
    idx         = r_idx;
    active      = |r_out;
    done        = r_done;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: wrap (SEL_W=2), halt (SEL_W=2) and SEL_W=3 instances.
// Expected values are pushed to exp_q as stimulus is driven and popped after the edge.
module tb_decoder_scan;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic load = 1'b0;
  logic step = 1'b0;
  logic dir = 1'b0;
  logic [1:0] sel2 = '0;
  logic [2:0] sel3 = '0;

  logic [3:0] out_a, out_h;
  logic [1:0] idx_a, idx_h, st_a, st_h, st_c;
  logic       act_a, act_h, act_c, done_a, done_h, done_c;
  logic [7:0] out_c;
  logic [2:0] idx_c;

  logic [15:0] exp_q[$];
  logic [15:0] got, exp_v;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .WRAP(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel2), .step(step),
`ifdef DECODER_SCAN_DIR_EN
    .dir(dir),
`endif
    .out(out_a), .idx(idx_a), .active(act_a), .done(done_a), .o_dbg_state(st_a)
  );

  decoder_scan #(.SEL_W(2), .WRAP(0)) u_hlt (
    .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel2), .step(step),
`ifdef DECODER_SCAN_DIR_EN
    .dir(dir),
`endif
    .out(out_h), .idx(idx_h), .active(act_h), .done(done_h), .o_dbg_state(st_h)
  );

  decoder_scan #(.SEL_W(3), .WRAP(1)) u_s3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel3), .step(step),
`ifdef DECODER_SCAN_DIR_EN
    .dir(dir),
`endif
    .out(out_c), .idx(idx_c), .active(act_c), .done(done_c), .o_dbg_state(st_c)
  );

  function automatic logic [15:0] pack_a();
    return {8'b0, out_a, idx_a, act_a, done_a};
  endfunction

  function automatic logic [15:0] pack_h();
    return {8'b0, out_h, idx_h, act_h, done_h};
  endfunction

  function automatic logic [15:0] pack_c();
    return {3'b0, out_c, idx_c, act_c, done_c};
  endfunction

  function automatic logic [15:0] exp2(input logic [3:0] o, input logic [1:0] i,
                                       input logic a, input logic d);
    return {8'b0, o, i, a, d};
  endfunction

  // Inputs change #1 after a rising edge; outputs are sampled #1 after the next one.
  task automatic drive(input logic r, input logic e, input logic l, input logic s,
                       input logic [1:0] s2, input logic [2:0] s3);
    rst = r; en = e; load = l; step = s; sel2 = s2; sel3 = s3;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, 2'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp2(4'b0000, 2'd0, 1'b0, 1'b0));
      drive(0, 1, 0, 0, 2'd0, 3'd0);
      got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL reset_idle[%0d] got=%h exp=%h", i, got, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (st_a !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", st_a, IDLE);
    else n_pass++;
    got = pack_c(); n_checks++;
    if (got !== 16'h0) $display("FAIL reset_sel3 got=%h exp=%h", got, 16'h0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    exp_q.push_back(exp2(4'b0100, 2'd2, 1'b1, 1'b0));
    drive(0, 1, 1, 0, 2'd2, 3'd0);
    exp_q.push_back(exp2(4'b1000, 2'd3, 1'b1, 1'b0));
    exp_q.push_back(exp2(4'b0001, 2'd0, 1'b1, 1'b1));
    exp_q.push_back(exp2(4'b0001, 2'd0, 1'b1, 1'b0));
    got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL wrap_load got=%h exp=%h", got, exp_v);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, (i < 2), 2'd0, 3'd0);
      got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL wrap_step[%0d] got=%h exp=%h", i, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    exp_q.push_back(exp2(4'b1000, 2'd3, 1'b1, 1'b0));
    exp_q.push_back(exp2(4'b0000, 2'd3, 1'b0, 1'b1));
    exp_q.push_back(exp2(4'b0000, 2'd3, 1'b0, 1'b0));
    exp_q.push_back(exp2(4'b0000, 2'd3, 1'b0, 1'b0));
    drive(0, 1, 1, 0, 2'd3, 3'd0);
    got = pack_h(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL halt_load got=%h exp=%h", got, exp_v);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, (i < 2), 2'd0, 3'd0);
      got = pack_h(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL halt_step[%0d] got=%h exp=%h", i, got, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (st_h !== HALT) $display("FAIL halt_state got=%0d exp=%0d", st_h, HALT);
    else n_pass++;
  endtask

  task automatic test_load_step_en();
    exp_q.push_back(exp2(4'b0010, 2'd1, 1'b1, 1'b0));
    drive(0, 1, 1, 1, 2'd1, 3'd0);
    got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL load_prio got=%h exp=%h", got, exp_v);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp2(4'b0010, 2'd1, 1'b1, 1'b0));
      drive(0, 0, 0, 1, 2'd0, 3'd0);
      got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL en_hold[%0d] got=%h exp=%h", i, got, exp_v);
      else n_pass++;
    end
    // Terminal index reached, then load+step together: load wins, no done.
    exp_q.push_back(exp2(4'b1000, 2'd3, 1'b1, 1'b0));
    exp_q.push_back(exp2(4'b0001, 2'd0, 1'b1, 1'b0));
    drive(0, 1, 1, 0, 2'd3, 3'd0);
    got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL term_load got=%h exp=%h", got, exp_v);
    else n_pass++;
    drive(0, 1, 1, 1, 2'd0, 3'd0);
    got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL term_load_step got=%h exp=%h", got, exp_v);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(exp2(4'b0100, 2'd2, 1'b1, 1'b0));
    exp_q.push_back(exp2(4'b0000, 2'd0, 1'b0, 1'b0));
    exp_q.push_back(exp2(4'b0000, 2'd0, 1'b0, 1'b0));
    drive(0, 1, 1, 0, 2'd2, 3'd0);
    got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL mid_load got=%h exp=%h", got, exp_v);
    else n_pass++;
    drive(1, 0, 1, 1, 2'd1, 3'd0);
    got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL mid_reset got=%h exp=%h", got, exp_v);
    else n_pass++;
    drive(0, 1, 0, 1, 2'd0, 3'd0);
    got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL idle_step got=%h exp=%h", got, exp_v);
    else n_pass++;
  endtask

  task automatic test_scan8();
    logic [2:0] ei;
    logic [7:0] eo;
    exp_q.push_back({3'b0, 8'h01, 3'd0, 1'b1, 1'b0});
    drive(0, 1, 1, 0, 2'd0, 3'd0);
    got = pack_c(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL scan8_load got=%h exp=%h", got, exp_v);
    else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      ei = 3'(k);
      eo = 8'h01 << ei;
      exp_q.push_back({3'b0, eo, ei, 1'b1, (k == 8)});
      drive(0, 1, 0, 1, 2'd0, 3'd0);
      got = pack_c(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL scan8_up[%0d] got=%h exp=%h", k, got, exp_v);
      else n_pass++;
    end
`ifdef DECODER_SCAN_DIR_EN
    exp_q.push_back({3'b0, 8'h01, 3'd0, 1'b1, 1'b0});
    drive(0, 1, 1, 0, 2'd0, 3'd0);
    got = pack_c(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL scan8_dn_load got=%h exp=%h", got, exp_v);
    else n_pass++;
    dir = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      ei = 3'(8 - k);
      eo = 8'h01 << ei;
      exp_q.push_back({3'b0, eo, ei, 1'b1, (k == 1)});
      drive(0, 1, 0, 1, 2'd0, 3'd0);
      got = pack_c(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL scan8_dn[%0d] got=%h exp=%h", k, got, exp_v);
      else n_pass++;
    end
    dir = 1'b0;
`endif
  endtask

  task automatic test_random();
    logic       m_run, m_done, l, s, e;
    logic [1:0] m_idx, sl;
    logic [3:0] m_out;
    m_run = 1'b0; m_idx = 2'd0;
    exp_q.push_back(16'h0);
    drive(1, 1, 0, 0, 2'd0, 3'd0);
    got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL rand_reset got=%h exp=%h", got, exp_v);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      l  = ($urandom_range(0, 3) == 0);
      s  = 1'($urandom_range(0, 1));
      e  = ($urandom_range(0, 4) != 0);
      sl = 2'($urandom_range(0, 3));
      m_done = 1'b0;
      if (e) begin
        if (l) begin
          m_run = 1'b1; m_idx = sl;
        end else if (s && m_run) begin
          m_done = (m_idx == 2'd3);
          m_idx  = m_idx + 2'd1;
        end
      end
      m_out = m_run ? (4'b0001 << m_idx) : 4'b0000;
      exp_q.push_back(exp2(m_out, m_idx, m_run, m_done));
      drive(0, e, l, s, sl, 3'd0);
      got = pack_a(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL rand[%0d] got=%h exp=%h", i, got, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_wrap();
    test_halt();
    test_load_step_en();
    test_reset_mid();
    test_scan8();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised registered one-hot decoder with auto-scan. Decodes a `SEL_W`-bit select into a `2**SEL_W`-bit one-hot output, registered, and can then step the active line forward one position per request with wrap-around or halt-at-end. Drives row/column strobes and channel enables in the same designs that use the plain 2-to-4 combinational decoder, where the active line must be held and sequenced rather than recomputed every cycle.

## Interface
Parameters:
- `SEL_W`, 2: select width, must be ≥ 1.
- `WRAP`, 1: 1 means stepping past the last line wraps to line 0; 0 means stepping past the last line halts.
- `N_OUT`, derived localparam `2**SEL_W`, not overridable: output width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable; 0 freezes all state and outputs.
- `load`  in  1  capture `sel` and decode it.
- `sel`  in  SEL_W  line index to activate on `load`.
- `step`  in  1  advance the active line by one position.
- `out`  out  N_OUT  registered one-hot output; all-zero when inactive.
- `idx`  out  SEL_W  binary index of the active line.
- `active`  out  1  high when `out` is non-zero.
- `done`  out  1  one-cycle pulse on the terminal step.

## Operation
States:
- IDLE: the reset state. `out`=0, `idx`=0, `active`=0.
- RUN: exactly one bit of `out` set, `out == 1 << idx`.
- HALT: reached only with `WRAP`=0. `out`=0, `active`=0, `idx` holds the last index.

Transitions, evaluated only when `en`=1:
- `load` in any state: go to RUN with `idx`←`sel`. `load` has priority over `step` in the same cycle; that `step` is dropped.
- `step` in RUN, not at the terminal index: `idx`←`idx`+1, computed modulo `N_OUT`.
- `step` in RUN at the terminal index (`N_OUT-1`):
  - `WRAP`=1: `idx`←0, stay in RUN, pulse `done`.
  - `WRAP`=0: go to HALT, pulse `done`.
- `step` in IDLE or HALT: ignored, no `done`.
- Otherwise: hold.

Other behaviour:
- `en`=0: all registers hold. `done` is forced to 0 that cycle.
- `sel` is sampled only on the `load` cycle.
- `out` is always either all-zero or exactly one-hot. No other value is ever driven.

## Timing
- All outputs are registered. Reset values: `out`=0, `idx`=0, `active`=0, `done`=0.
- `load` at edge N → `out`, `idx` and `active` valid after edge N, i.e. 1-cycle latency.
- `step` at edge N → new `out` after edge N. Continuous `step` advances one line per cycle.
- `done` is high for exactly the cycle following the terminal step.
- Reset mid-scan: state goes to IDLE on the next edge regardless of `load`, `step` or `en`. Reset overrides everything.
- Simultaneous `load` and terminal `step`: the load wins and `done` is not pulsed.

## Configuration
- `DECODER_SCAN_DIR_EN` defined:
  - Adds port `dir` (in, 1). `dir`=1 steps down.
  - Downward terminal index is 0. Stepping down from 0 wraps to `N_OUT-1` (`WRAP`=1) or goes to HALT (`WRAP`=0), with a `done` pulse in both cases.
  - `dir` is sampled together with `step`.
- Undefined: no `dir` port; up-stepping only. Behaviour is exactly as above.

## Structure
- Package `decoder_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, HALT} scan_state_t`.
  - Function `onehot(idx)` returning `1 << idx`, reusable by the combinational decoder.
- One natural sub-module: `onehot_dec`, a combinational `SEL_W`→`N_OUT` decoder. The `out` register is fed from it.
- Next-state logic is a single always_ff plus one always_comb.

## Test plan
Default `SEL_W`=2 unless stated.
1. Reset, then idle for 3 cycles → `out`=4'b0000, `active`=0, `done`=0.
2. `load` with `sel`=2'b10 → next cycle `out`=4'b0100, `idx`=2. Then `step` ×2 with `WRAP`=1 → `out`=4'b1000, then 4'b0001 with `done`=1 for exactly one cycle.
3. `WRAP`=0: `load` `sel`=3, then `step` → HALT, `out`=0, `done` pulse. A further `step` → no change, no `done`.
4. `load` `sel`=1 and `step` in the same cycle → `out`=4'b0010. Then `en`=0 with `step` held for 4 cycles → `out` stays 4'b0010.
5. Reset asserted while in RUN with `step`=1 → `out`=0 on the next cycle.
6. `SEL_W`=3: `load` `sel`=0, then 8 continuous `step`s → walking one through 8'b00000001…8'b10000000 and back to 8'b00000001. With `DECODER_SCAN_DIR_EN` defined and `dir`=1, the sequence reverses.
